decode_stage: RTL and testbench

//  RV32I decode stage sitting between the fetch stage and execute. It consumes the 64-bit

---
 rtl/decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage between fetch and execute.
//   Decodes {instr, pc} from fetch_dec_reg and reads operands from an internal
//   32x32 register file that writeback writes (with write-through bypass). It
//   detects load-use hazards and drives stall back to fetch. The decoded fields
//   are registered into the decode/execute pipeline register (dec_* outputs).
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   fetch_dec_reg              {instr[63:32], pc[31:0]} from fetch
//   flush                      branch/jump taken in EX, kill the decode slot
//   ex_mem_read, ex_rd         load currently in EX and its destination
//   wb_en, wb_rd, wb_data      register-file write port
//   stall                      combinational, fetch holds its outputs
//   dec_*                      decode/execute pipeline register
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2*XLEN-1:0] fetch_dec_reg,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              dec_valid,
  output logic [XLEN-1:0]   dec_pc,
  output logic [XLEN-1:0]   dec_rs1_data,
  output logic [XLEN-1:0]   dec_rs2_data,
  output logic [XLEN-1:0]   dec_imm,
  output logic [4:0]        dec_rs1,
  output logic [4:0]        dec_rs2,
  output logic [4:0]        dec_rd,
  output logic [3:0]        dec_alu_op,
  output logic              dec_alu_src,
  output logic [2:0]        dec_branch_type,
  output logic              dec_mem_read,
  output logic              dec_mem_write,
  output logic [2:0]        dec_funct3,
  output logic              dec_reg_write,
  output logic [1:0]        dec_wb_sel,
  output logic              dec_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic [2:0]      branch_type;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic            illegal;
  } dec_t;

  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [6:0]      opcode;
  logic [4:0]      rd_f;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign instr  = fetch_dec_reg[2*XLEN-1:XLEN];
  assign pc     = fetch_dec_reg[XLEN-1:0];
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Register file. x0 is never written and its read is forced to zero below.
  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wb_write;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign wb_write = wb_en && (wb_rd != 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Same-cycle writeback is bypassed so decode never sees a stale operand.
  assign rs1_val = (rs1_f == 5'd0) ? '0 :
                   (wb_write && wb_rd == rs1_f) ? wb_data : regs[rs1_f];
  assign rs2_val = (rs2_f == 5'd0) ? '0 :
                   (wb_write && wb_rd == rs2_f) ? wb_data : regs[rs2_f];

  dec_t d;
  logic rs1_used;
  logic rs2_used;
  logic rd_used;
  logic pc_as_rs1;
  logic legal;

  always_comb begin
    d         = '0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    rd_used   = 1'b0;
    pc_as_rs1 = 1'b0;
    legal     = 1'b1;
    d.valid   = 1'b1;
    d.pc      = pc;
    case (opcode)
      OPC_LUI: begin
        rd_used   = 1'b1;
        d.imm     = imm_u;
        d.alu_op  = ALU_PASSB;
        d.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        rd_used   = 1'b1;
        pc_as_rs1 = 1'b1;
        d.imm     = imm_u;
        d.alu_op  = ALU_ADD;
        d.alu_src = 1'b1;
      end
      OPC_JAL: begin
        rd_used       = 1'b1;
        d.imm         = imm_j;
        d.alu_src     = 1'b1;
        d.branch_type = BR_JUMP;
        d.wb_sel      = WB_PC4;
      end
      OPC_JALR: begin
        legal         = (funct3 == 3'd0);
        rs1_used      = 1'b1;
        rd_used       = 1'b1;
        d.imm         = imm_i;
        d.alu_src     = 1'b1;
        d.branch_type = BR_JUMP;
        d.wb_sel      = WB_PC4;
      end
      OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        d.imm    = imm_b;
        d.alu_op = ALU_SUB;
        case (funct3)
          3'd0:    d.branch_type = BR_BEQ;
          3'd1:    d.branch_type = BR_BNE;
          3'd4:    d.branch_type = BR_BLT;
          3'd5:    d.branch_type = BR_BGE;
          3'd6:    d.branch_type = BR_BLTU;
          3'd7:    d.branch_type = BR_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal      = (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        rs1_used   = 1'b1;
        rd_used    = 1'b1;
        d.imm      = imm_i;
        d.alu_src  = 1'b1;
        d.mem_read = 1'b1;
        d.funct3   = funct3;
        d.wb_sel   = WB_MEM;
      end
      OPC_STORE: begin
        legal       = (funct3 inside {3'd0, 3'd1, 3'd2});
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        d.imm       = imm_s;
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.funct3    = funct3;
      end
      OPC_OPIMM: begin
        rs1_used  = 1'b1;
        rd_used   = 1'b1;
        d.imm     = imm_i;
        d.alu_src = 1'b1;
        case (funct3)
          3'd0: d.alu_op = ALU_ADD;
          3'd1: begin
            d.alu_op = ALU_SLL;
            legal    = (funct7 == 7'h00);
          end
          3'd2: d.alu_op = ALU_SLT;
          3'd3: d.alu_op = ALU_SLTU;
          3'd4: d.alu_op = ALU_XOR;
          3'd5: begin
            d.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            legal    = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'd6: d.alu_op = ALU_OR;
          default: d.alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        rd_used  = 1'b1;
        // funct7 bit 5 only selects SUB/SRA; every other non-zero funct7 is an extension.
        legal = (funct7 == 7'h00) ||
                (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
        case (funct3)
          3'd0:    d.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'd1:    d.alu_op = ALU_SLL;
          3'd2:    d.alu_op = ALU_SLT;
          3'd3:    d.alu_op = ALU_SLTU;
          3'd4:    d.alu_op = ALU_XOR;
          3'd5:    d.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'd6:    d.alu_op = ALU_OR;
          default: d.alu_op = ALU_AND;
        endcase
      end
      default: legal = 1'b0;
    endcase

    d.rs1       = rs1_used ? rs1_f : 5'd0;
    d.rs2       = rs2_used ? rs2_f : 5'd0;
    d.rd        = rd_used ? rd_f : 5'd0;
    d.reg_write = rd_used && (rd_f != 5'd0);
    d.rs1_data  = pc_as_rs1 ? pc : (rs1_used ? rs1_val : '0);
    d.rs2_data  = rs2_used ? rs2_val : '0;

    // Illegal instructions travel to EX only as a marker with the pc.
    if (!legal) begin
      d         = '0;
      d.valid   = 1'b1;
      d.illegal = 1'b1;
      d.pc      = pc;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
    end

    // All-zero word is what fetch presents after reset: treat as a bubble.
    if (instr == '0) begin
      d        = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
    end
  end

  logic haz;

  assign haz = ex_mem_read && (ex_rd != 5'd0) &&
               ((rs1_used && ex_rd == rs1_f) || (rs2_used && ex_rd == rs2_f));
  assign stall = haz && !flush;

  dec_t dec_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_q <= '0;
    end else if (flush || haz) begin
      dec_q <= '0;
    end else begin
      dec_q <= d;
    end
  end

  assign dec_valid       = dec_q.valid;
  assign dec_pc          = dec_q.pc;
  assign dec_rs1_data    = dec_q.rs1_data;
  assign dec_rs2_data    = dec_q.rs2_data;
  assign dec_imm         = dec_q.imm;
  assign dec_rs1         = dec_q.rs1;
  assign dec_rs2         = dec_q.rs2;
  assign dec_rd          = dec_q.rd;
  assign dec_alu_op      = dec_q.alu_op;
  assign dec_alu_src     = dec_q.alu_src;
  assign dec_branch_type = dec_q.branch_type;
  assign dec_mem_read    = dec_q.mem_read;
  assign dec_mem_write   = dec_q.mem_write;
  assign dec_funct3      = dec_q.funct3;
  assign dec_reg_write   = dec_q.reg_write;
  assign dec_wb_sel      = dec_q.wb_sel;
  assign dec_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
//   A table of directed vectors (stimulus plus hand-computed expected outputs)
//   is applied one per cycle; hand-written sequences cover reset, the load-use
//   stall/release pair and an asynchronous reset in the middle of a stream.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] fetch_dec_reg = '0;
  logic        flush = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_rs1_data;
  logic [31:0] dec_rs2_data;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [3:0]  dec_alu_op;
  logic        dec_alu_src;
  logic [2:0]  dec_branch_type;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic [2:0]  dec_funct3;
  logic        dec_reg_write;
  logic [1:0]  dec_wb_sel;
  logic        dec_illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rstn(rstn), .fetch_dec_reg(fetch_dec_reg), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall(stall), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_alu_op(dec_alu_op),
    .dec_alu_src(dec_alu_src), .dec_branch_type(dec_branch_type),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_funct3(dec_funct3), .dec_reg_write(dec_reg_write), .dec_wb_sel(dec_wb_sel),
    .dec_illegal(dec_illegal)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        valid;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src;
    logic [2:0]  br;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic        rw;
    logic [1:0]  wbs;
    logic        ill;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  task automatic drive(input vec_t v);
    fetch_dec_reg = {v.instr, v.pc};
    flush         = v.flush;
    ex_mem_read   = v.ex_mr;
    ex_rd         = v.ex_rd;
    wb_en         = v.wb_en;
    wb_rd         = v.wb_rd;
    wb_data       = v.wb_data;
  endtask

  task automatic check_out(input string t, input vec_t v);
    chk({t, ".valid"},   {31'd0, dec_valid},       {31'd0, v.valid});
    chk({t, ".pc"},      dec_pc,                   v.valid ? v.pc : 32'd0);
    chk({t, ".rs1_data"}, dec_rs1_data,            v.rs1d);
    chk({t, ".rs2_data"}, dec_rs2_data,            v.rs2d);
    chk({t, ".imm"},     dec_imm,                  v.imm);
    chk({t, ".rs1"},     {27'd0, dec_rs1},         {27'd0, v.rs1});
    chk({t, ".rs2"},     {27'd0, dec_rs2},         {27'd0, v.rs2});
    chk({t, ".rd"},      {27'd0, dec_rd},          {27'd0, v.rd});
    chk({t, ".alu_op"},  {28'd0, dec_alu_op},      {28'd0, v.alu});
    chk({t, ".alu_src"}, {31'd0, dec_alu_src},     {31'd0, v.src});
    chk({t, ".branch"},  {29'd0, dec_branch_type}, {29'd0, v.br});
    chk({t, ".mem_rd"},  {31'd0, dec_mem_read},    {31'd0, v.mr});
    chk({t, ".mem_wr"},  {31'd0, dec_mem_write},   {31'd0, v.mw});
    chk({t, ".funct3"},  {29'd0, dec_funct3},      {29'd0, v.f3});
    chk({t, ".reg_wr"},  {31'd0, dec_reg_write},   {31'd0, v.rw});
    chk({t, ".wb_sel"},  {30'd0, dec_wb_sel},      {30'd0, v.wbs});
    chk({t, ".illegal"}, {31'd0, dec_illegal},     {31'd0, v.ill});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: instr, pc, flush, ex_mr, ex_rd, wb_en, wb_rd, wb_data |
    //          stall, valid, rs1d, rs2d, imm, rs1, rs2, rd, alu, src, br, mr, mw, f3, rw, wbs, ill
    vecs[0]  = '{enc_r(7'h00, 0, 5, 0, 3, 7'h33), 32'h100, 0, 0, 0, 1, 5, 32'h1234,
                 0, 1, 32'h1234, 0, 0, 5, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{enc_r(7'h20, 2, 5, 0, 4, 7'h33), 32'h104, 0, 0, 0, 1, 2, 32'h80,
                 0, 1, 32'h1234, 32'h80, 0, 5, 2, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{enc_i(12'hFFF, 5, 0, 6, 7'h13), 32'h108, 0, 0, 0, 0, 0, 0,
                 0, 1, 32'h1234, 0, 32'hFFFFFFFF, 5, 0, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{enc_i(12'h403, 2, 5, 7, 7'h13), 32'h10C, 0, 0, 0, 0, 0, 0,
                 0, 1, 32'h80, 0, 32'h403, 2, 0, 7, 7, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{enc_u(20'hABCDE, 8, 7'h37), 32'h110, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 32'hABCDE000, 0, 0, 8, 10, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{enc_u(20'h00001, 9, 7'h17), 32'h200, 0, 0, 0, 0, 0, 0,
                 0, 1, 32'h200, 0, 32'h1000, 0, 0, 9, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{enc_b(13'h1FF8, 2, 1, 1, 7'h63), 32'h40, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 32'h80, 32'hFFFFFFF8, 1, 2, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{enc_j(21'h10, 1, 7'h6F), 32'h44, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 32'h10, 0, 0, 1, 0, 1, 7, 0, 0, 0, 1, 2, 0};
    vecs[8]  = '{enc_i(12'h008, 5, 0, 0, 7'h67), 32'h48, 0, 0, 0, 0, 0, 0,
                 0, 1, 32'h1234, 0, 32'h8, 5, 0, 0, 0, 1, 7, 0, 0, 0, 0, 2, 0};
    vecs[9]  = '{enc_i(12'hFFC, 2, 2, 10, 7'h03), 32'h4C, 0, 0, 0, 0, 0, 0,
                 0, 1, 32'h80, 0, 32'hFFFFFFFC, 2, 0, 10, 0, 1, 0, 1, 0, 2, 1, 1, 0};
    vecs[10] = '{enc_s(12'h003, 5, 2, 0, 7'h23), 32'h50, 0, 0, 0, 0, 0, 0,
                 0, 1, 32'h80, 32'h1234, 32'h3, 2, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{32'h00000013, 32'h54, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{32'h00000073, 32'h58, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[13] = '{enc_r(7'h00, 0, 0, 0, 11, 7'h33), 32'h5C, 0, 0, 0, 1, 0, 32'hFFFFFFFF,
                 0, 1, 0, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{enc_r(7'h00, 5, 0, 6, 12, 7'h33), 32'h60, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 32'h1234, 0, 0, 5, 12, 8, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{32'h00000000, 32'h64, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{enc_r(7'h00, 0, 5, 0, 3, 7'h33), 32'h68, 1, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{enc_r(7'h00, 5, 0, 0, 3, 7'h33), 32'h6C, 0, 1, 0, 0, 0, 0,
                 0, 1, 0, 32'h1234, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[18] = '{enc_r(7'h00, 0, 5, 0, 3, 7'h33), 32'h70, 1, 1, 5, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[19] = '{enc_u(20'h00040, 3, 7'h37), 32'h74, 0, 1, 8, 0, 0, 0,
                 0, 1, 0, 0, 32'h00040000, 0, 0, 3, 10, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[20] = '{enc_i(12'h007, 1, 0, 3, 7'h13), 32'h78, 0, 1, 7, 0, 0, 0,
                 0, 1, 0, 0, 32'h7, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[21] = '{enc_r(7'h01, 2, 1, 0, 3, 7'h33), 32'h7C, 0, 0, 0, 0, 0, 0,
                 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[22] = '{enc_b(13'h0010, 5, 0, 0, 7'h63), 32'h80, 0, 1, 5, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset: bubble while held, and stays a bubble on an all-zero fetch word.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.valid",  {31'd0, dec_valid},     32'd0);
    chk("reset.pc",     dec_pc,                 32'd0);
    chk("reset.reg_wr", {31'd0, dec_reg_write}, 32'd0);
    chk("reset.stall",  {31'd0, stall},         32'd0);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d.valid", c), {31'd0, dec_valid}, 32'd0);
      chk($sformatf("idle%0d.stall", c), {31'd0, stall},     32'd0);
    end

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].stall});
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", i), vecs[i]);
    end

    // Load-use on the store data register: one bubble, then the store issues.
    @(negedge clk);
    fetch_dec_reg = {enc_s(12'h000, 7, 2, 2, 7'h23), 32'h90};
    flush = 1'b0; wb_en = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    chk("sw_haz.stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("sw_haz.valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    chk("sw_go.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("sw_go.valid",    {31'd0, dec_valid},     32'd1);
    chk("sw_go.mem_wr",   {31'd0, dec_mem_write}, 32'd1);
    chk("sw_go.imm",      dec_imm,                32'd0);
    chk("sw_go.rs2",      {27'd0, dec_rs2},       32'd7);
    chk("sw_go.rs1_data", dec_rs1_data,           32'h80);
    chk("sw_go.pc",       dec_pc,                 32'h90);

    // Asynchronous reset between clock edges clears the pipeline register at once.
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst.valid",  {31'd0, dec_valid},     32'd0);
    chk("async_rst.mem_wr", {31'd0, dec_mem_write}, 32'd0);
    chk("async_rst.pc",     dec_pc,                 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    fetch_dec_reg = {enc_r(7'h00, 0, 5, 0, 3, 7'h33), 32'hA0};
    @(posedge clk);
    #1;
    chk("post_rst.valid",    {31'd0, dec_valid}, 32'd1);
    chk("post_rst.rs1_data", dec_rs1_data,       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
